// File: rtl/ex_stage.sv
// ex_stage: execute stage with a single-cycle ALU, an iterative mul/div unit and the EX/MEM register.
// In: operands, imm, pc, alu_op/alu_src, control flags, rd, mem_stall_in. Out: EX/MEM bundle, ex_stall_out.
module ex_stage #(
  parameter int BIT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIT_W-1:0] rs1_data,
  input  logic [BIT_W-1:0] rs2_data,
  input  logic [BIT_W-1:0] imm,
  input  logic [BIT_W-1:0] pc_in,
  input  logic [3:0]       alu_op,
  input  logic             alu_src,
  input  logic             memrd_in,
  input  logic             memwr_in,
  input  logic             mem2reg_in,
  input  logic             regwr_in,
  input  logic [4:0]       rd_in,
  input  logic             mem_stall_in,
  output logic [BIT_W-1:0] alu_result_out,
  output logic [BIT_W-1:0] mem_wdata_out,
  output logic [BIT_W-1:0] PC_plus_4_out,
  output logic             memrd_out,
  output logic             memwr_out,
  output logic             mem2reg_out,
  output logic             regwr_out,
  output logic [4:0]       rd_out,
  output logic             ex_stall_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           st_q;
  logic [4:0]       cnt_q;
  logic [3:0]       op_q;
  logic             neg_q;
  logic [BIT_W-1:0] acc_q, opa_q, opb_q;
  logic [BIT_W-1:0] acc_d, opa_d, opb_d;

  logic [BIT_W-1:0] b_op, alu_res, md_res, res;
  logic [BIT_W:0]   dtmp, ddiff;
  logic [4:0]       shamt;
  logic             is_md, sgn_op, sa, sb;

  assign b_op   = alu_src ? imm : rs2_data;
  assign shamt  = b_op[4:0];
  assign is_md  = alu_op[3] & (alu_op[2] | (alu_op[1] & alu_op[0]));
  assign sgn_op = (alu_op == 4'd12) | (alu_op == 4'd14);
  assign sa     = sgn_op & rs1_data[BIT_W-1];
  assign sb     = sgn_op & b_op[BIT_W-1];

  assign ex_stall_out = (st_q == BUSY) | ((st_q == IDLE) & is_md);

  always_comb begin
    alu_res = '0;
    unique case (alu_op)
      4'd0:  alu_res = rs1_data + b_op;
      4'd1:  alu_res = rs1_data - b_op;
      4'd2:  alu_res = rs1_data << shamt;
      4'd3:  alu_res = {{(BIT_W-1){1'b0}},
                        $signed(rs1_data) < $signed(b_op)};
      4'd4:  alu_res = {{(BIT_W-1){1'b0}}, rs1_data < b_op};
      4'd5:  alu_res = rs1_data ^ b_op;
      4'd6:  alu_res = rs1_data >> shamt;
      4'd7:  alu_res = $signed(rs1_data) >>> shamt;
      4'd8:  alu_res = rs1_data | b_op;
      4'd9:  alu_res = rs1_data & b_op;
      4'd10: alu_res = b_op;
      default: alu_res = '0;
    endcase
  end

  // MUL: shift-add on raw operands (low half is sign-agnostic).
  // DIV/REM: restoring step; acc = partial remainder, opb shifts
  // dividend out and quotient in. Divisor 0 yields all-ones quotient.
  always_comb begin
    acc_d = acc_q;
    opa_d = opa_q;
    opb_d = opb_q;
    dtmp  = {acc_q, opb_q[BIT_W-1]};
    ddiff = dtmp - {1'b0, opa_q};
    if (op_q == 4'd11) begin
      acc_d = acc_q + (opb_q[0] ? opa_q : '0);
      opa_d = opa_q << 1;
      opb_d = opb_q >> 1;
    end else begin
      acc_d = ddiff[BIT_W] ? dtmp[BIT_W-1:0] : ddiff[BIT_W-1:0];
      opb_d = {opb_q[BIT_W-2:0], ~ddiff[BIT_W]};
    end
  end

  always_comb begin
    md_res = acc_q;
    unique case (1'b1)
      ~op_q[2]:            md_res = acc_q;
      op_q[2] & ~op_q[1]:  md_res = neg_q ? -opb_q : opb_q;
      op_q[2] &  op_q[1]:  md_res = neg_q ? -acc_q : acc_q;
    endcase
  end

  assign res = (st_q == DONE) ? md_res : alu_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= IDLE;
      cnt_q <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      acc_q <= '0;
      opa_q <= '0;
      opb_q <= '0;
    end else if (!mem_stall_in) begin
      unique case (st_q)
        IDLE: if (is_md) begin
          st_q  <= BUSY;
          cnt_q <= '0;
          op_q  <= alu_op;
          acc_q <= '0;
          // quotient negates only for a nonzero divisor
          neg_q <= alu_op[1] ? sa : ((sa ^ sb) & (|b_op));
          if (alu_op == 4'd11) begin
            opa_q <= rs1_data;
            opb_q <= b_op;
          end else begin
            opa_q <= sb ? -b_op : b_op;
            opb_q <= sa ? -rs1_data : rs1_data;
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          opa_q <= opa_d;
          opb_q <= opb_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) st_q <= DONE;
        end
        DONE: st_q <= IDLE;
        default: st_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result_out <= '0;
      mem_wdata_out  <= '0;
      PC_plus_4_out  <= '0;
      rd_out         <= '0;
      memrd_out      <= 1'b0;
      memwr_out      <= 1'b0;
      mem2reg_out    <= 1'b0;
      regwr_out      <= 1'b0;
    end else if (!mem_stall_in) begin
      alu_result_out <= res;
      mem_wdata_out  <= rs2_data;
      PC_plus_4_out  <= pc_in + BIT_W'(4);
      rd_out         <= rd_in;
      memrd_out      <= memrd_in   & ~ex_stall_out;
      memwr_out      <= memwr_in   & ~ex_stall_out;
      mem2reg_out    <= mem2reg_in & ~ex_stall_out;
      regwr_out      <= regwr_in   & ~ex_stall_out;
    end
  end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter BIT_W, default 32, datapath width; all data ports are BIT_W wide unless stated.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have inputs rs1_data, rs2_data, imm, pc_in  input  BIT_W  ID/EX operands, immediate, instruction PC.
REQ-005 SHALL have input alu_op  input  4  operation code per REQ-012.
REQ-006 SHALL have input alu_src  input  1  1: operand B = imm, 0: operand B = rs2_data.
REQ-007 SHALL have inputs memrd_in, memwr_in, mem2reg_in, regwr_in  input  1 each  control flags carried to the memory stage.
REQ-008 SHALL have input rd_in  input  5  destination register.
REQ-009 SHALL have input mem_stall_in  input  1  downstream memory stage stalled; hold the EX/MEM register.
REQ-010 SHALL have outputs alu_result_out, mem_wdata_out, PC_plus_4_out  output  BIT_W; memrd_out, memwr_out, mem2reg_out, regwr_out  output  1; rd_out  output  5; all registered (EX/MEM register).
REQ-011 SHALL have output ex_stall_out  output  1  multi-cycle op in progress; upstream holds its inputs; combinational from state and alu_op.

Function
REQ-012 SHALL decode alu_op: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B, 11 MUL, 12 DIV, 13 DIVU, 14 REM, 15 REMU.
REQ-013 SHALL treat ops 0-10 as single-cycle: result computed combinationally, registered on the next edge; shifts use B[4:0]; SLT/SLTU produce 0 or 1; arithmetic wraps modulo 2^BIT_W.
REQ-014 SHALL implement ops 11-15 in an iterative unit with FSM IDLE, BUSY, DONE and a 5-bit iteration counter.
REQ-015 IDLE: muldiv op present and mem_stall_in=0 -> latch operand magnitudes and signs, counter=0, go BUSY; ex_stall_out=1 in this cycle.
REQ-016 BUSY: one shift-add (MUL) or restoring-subtract (DIV/REM) step per cycle; ex_stall_out=1; after 32 steps (counter wraps 31->0) go DONE.
REQ-017 DONE: ex_stall_out=0, sign-corrected result drives the EX/MEM register; if mem_stall_in=0 go IDLE, else stay DONE holding the result.
REQ-018 Muldiv latency: op presented in cycle 0 -> ex_stall_out high cycles 0-32 -> result in alu_result_out after edge ending cycle 33 (no downstream stall).
REQ-019 MUL SHALL return low BIT_W bits of the product (sign-agnostic).
REQ-020 Divide by zero: DIV/DIVU quotient = all ones; REM/REMU remainder = dividend; unit still takes full latency.
REQ-021 Signed overflow (0x80000000 / -1): DIV quotient = 0x80000000, REM = 0; remainder sign follows dividend.
REQ-022 mem_stall_in=1 SHALL hold every EX/MEM output and freeze the FSM (BUSY counter does not advance).
REQ-023 ex_stall_out=1 and mem_stall_in=0 SHALL load a bubble: memrd_out, memwr_out, mem2reg_out, regwr_out = 0; other outputs don't-care.
REQ-024 Otherwise EX/MEM loads: alu_result_out=result, mem_wdata_out=rs2_data, PC_plus_4_out=pc_in+4, rd_out=rd_in, control flags pass through.

Reset
REQ-025 rst_n low SHALL immediately force FSM to IDLE, counter 0, all registered outputs 0, regardless of in-progress operation.
REQ-026 After rst_n rises, first op SHALL be processed normally; an aborted muldiv is not resumed.

Verification
REQ-027 ADD rs1=5, imm=0xFFFFFFFD, alu_src=1, regwr_in=1, rd_in=3 -> next edge alu_result_out=2, regwr_out=1, rd_out=3, ex_stall_out=0.
REQ-028 MUL rs1=0xFFFFFFFF, rs2=3 -> ex_stall_out high 33 cycles, bubbles meanwhile, then alu_result_out=0xFFFFFFFD with regwr_out=1.
REQ-029 DIV rs1=-7, rs2=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 7/0 -> 0xFFFFFFFF; REMU 7/0 -> 7.
REQ-030 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0.
REQ-031 mem_stall_in held high 4 cycles in BUSY and again 3 cycles in DONE -> outputs frozen, total latency extended by 7, result unchanged.
REQ-032 rst_n pulsed low at BUSY step 10 -> outputs 0 asynchronously, ex_stall_out=0 with non-muldiv op; following SUB 9-4 yields 5.
